apb_req_arbiter: RTL

// Round-robin arbiter and sequencer that shares one APB master command port among NREQ requesters.

---
 rtl/apb_req_arbiter.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/apb_req_arbiter.sv
// Round-robin arbiter sharing one APB master command port among NREQ clients.
// Sequences ARB -> CMD -> WAIT -> RSP with a watchdog on the completion wait.
module apb_req_arbiter #(
  parameter int NREQ    = 4,
  parameter int AW      = 8,
  parameter int DW      = 8,
  parameter int TIMEOUT = 16
) (
  input  logic               pclk,
  input  logic               preset,
  input  logic [NREQ-1:0]    req_valid_i,
  input  logic [NREQ-1:0]    req_write_i,
  input  logic [NREQ*AW-1:0] req_addr_i,
  input  logic [NREQ*DW-1:0] req_wdata_i,
  output logic [NREQ-1:0]    req_ready_o,
  output logic [NREQ-1:0]    rsp_valid_o,
  output logic [DW-1:0]      rsp_rdata_o,
  output logic               rsp_err_o,
  output logic               m_valid_o,
  output logic               m_write_o,
  output logic [AW-1:0]      m_addr_o,
  output logic [DW-1:0]      m_wdata_o,
  input  logic               m_ready_i,
  input  logic               m_done_i,
  input  logic [DW-1:0]      m_rdata_i,
  output logic [NREQ-1:0]    grant_o,
  output logic               busy_o
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int TW = $clog2(TIMEOUT) + 1;

  typedef enum logic [1:0] {
    S_ARB,
    S_CMD,
    S_WAIT,
    S_RSP
  } state_t;

  state_t          r_state;
  state_t          w_next;
  logic [PW-1:0]   r_ptr;
  logic [NREQ-1:0] r_grant;
  logic            r_write;
  logic [AW-1:0]   r_addr;
  logic [DW-1:0]   r_wdata;
  logic [TW-1:0]   r_timer;
  logic [DW-1:0]   r_rdata;
  logic            r_err;

  logic [PW-1:0]   w_win;
  logic [NREQ-1:0] w_win_oh;
  logic            w_any;
  logic            w_tmo;
  logic [NREQ-1:0] w_ready;

  // Search starts one past the last owner so every client gets a turn.
  always_comb begin
    int j;
    logic [PW-1:0] idx;
    w_win = r_ptr;
    w_any = 1'b0;
    for (int k = 1; k <= NREQ; k++) begin
      j   = (int'(r_ptr) + k) % NREQ;
      idx = PW'(j);
      if (!w_any && req_valid_i[idx]) begin
        w_any = 1'b1;
        w_win = idx;
      end
    end
  end

  always_comb begin
    w_win_oh        = '0;
    w_win_oh[w_win] = 1'b1;
  end

  assign w_tmo = (r_timer == TW'(TIMEOUT - 1));

  always_comb begin
    w_next  = r_state;
    w_ready = '0;
    unique case (r_state)
      S_ARB: begin
        if (w_any) begin
          w_next  = S_CMD;
          w_ready = w_win_oh;
        end
      end
      S_CMD: begin
        if (m_ready_i) w_next = S_WAIT;
      end
      S_WAIT: begin
        if (m_done_i || w_tmo) w_next = S_RSP;
      end
      S_RSP: w_next = S_ARB;
      default: w_next = S_ARB;
    endcase
  end

  always_ff @(posedge pclk) begin
    if (preset) begin
      r_state <= S_ARB;
      r_ptr   <= PW'(NREQ - 1);
      r_grant <= '0;
      r_write <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_timer <= '0;
      r_rdata <= '0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_next;
      unique case (r_state)
        S_ARB: begin
          if (w_any) begin
            r_ptr   <= w_win;
            r_grant <= w_win_oh;
            r_write <= req_write_i[w_win];
            r_addr  <= req_addr_i[w_win*AW +: AW];
            r_wdata <= req_wdata_i[w_win*DW +: DW];
          end
        end
        S_CMD: begin
          if (m_ready_i) r_timer <= '0;
        end
        S_WAIT: begin
          r_timer <= r_timer + TW'(1);
          // A completion on the last watchdog cycle still counts as success.
          if (m_done_i) begin
            r_rdata <= r_write ? '0 : m_rdata_i;
            r_err   <= 1'b0;
          end else if (w_tmo) begin
            r_rdata <= '0;
            r_err   <= 1'b1;
          end
        end
        S_RSP: r_grant <= '0;
        default: r_grant <= '0;
      endcase
    end
  end

  assign req_ready_o = w_ready;
  assign rsp_valid_o = (r_state == S_RSP) ? r_grant : '0;
  assign rsp_rdata_o = r_rdata;
  assign rsp_err_o   = r_err;
  assign m_valid_o   = (r_state == S_CMD);
  assign m_write_o   = r_write;
  assign m_addr_o    = r_addr;
  assign m_wdata_o   = r_wdata;
  assign grant_o     = r_grant;
  assign busy_o      = (r_state != S_ARB);

endmodule
